// File: rtl/inv_cov_2.sv
// Rebuilds the inverse covariance P = L^-T L^-1 from the packed inverse-Cholesky factor S using one shared Q16.16 multiplier.
// Latency 7+3*MULT_LAT enabled cycles from capture to P_valid; a new S_valid rise is accepted only in IDLE, and rises while busy are dropped.
module inv_cov_2 #(
  parameter int MULT_LAT = 7,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [3*DATA_W-1:0] S,
  input  logic                S_valid,
  output logic [3*DATA_W-1:0] P,
  output logic                P_valid,
  output logic                busy
);
  localparam int L     = MULT_LAT;
  localparam int LAST  = 3*L + 6;
  localparam int CNT_W = $clog2(LAST + 1);

  typedef enum logic [2:0] {IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, ISSUE_C, WAIT_C, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s_valid_d1_q, s_valid_d1_d;
  logic [DATA_W-1:0]   s11_q, s11_d, s21_q, s21_d, s22_q, s22_d;
  logic [DATA_W-1:0]   m1_q, m1_d, m2_q, m2_d, t_q, t_d, u_q, u_d, m5_q, m5_d, m6_q, m6_d;
  logic [DATA_W-1:0]   pipe_q [L];
  logic [DATA_W-1:0]   pipe_d [L];
  logic [3*DATA_W-1:0] p_q, p_d;
  logic                p_valid_q, p_valid_d, busy_q, busy_d;
  logic [DATA_W-1:0]   mul_a, mul_b, prod_out;

  // Floor-truncated Q16.16 product; saturates when bits [63:47] disagree.
  function automatic logic [DATA_W-1:0] fx_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [63:0] pa, pb, prod, sh;
    pa   = {{32{a[DATA_W-1]}}, a};
    pb   = {{32{b[DATA_W-1]}}, b};
    prod = pa * pb;
    sh   = prod >>> 16;
    if (sh[63:31] == {33{sh[31]}}) return sh[31:0];
    return prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  function automatic logic [DATA_W-1:0] fx_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] == sum[DATA_W-1]) return sum[DATA_W-1:0];
    return sum[DATA_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  function automatic logic [DATA_W-1:0] fx_neg(input logic [DATA_W-1:0] a);
    if (a == 32'h8000_0000) return 32'h7FFF_FFFF;
    return 32'd0 - a;
  endfunction

  assign prod_out = pipe_q[L-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_valid_d1_d = S_valid;
    s11_d = s11_q; s21_d = s21_q; s22_d = s22_q;
    m1_d  = m1_q;  m2_d  = m2_q;  t_d   = t_q;
    u_d   = u_q;   m5_d  = m5_q;  m6_d  = m6_q;
    p_d       = p_q;
    p_valid_d = p_valid_q;
    busy_d    = busy_q;
    mul_a     = '0;
    mul_b     = '0;

    // cnt_q == N-1 selects operands latched at edge cN; results of an issue at cN are taken at cnt_q == N+L-1.
    if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if      (cnt_q == CNT_W'(0))     begin mul_a = s11_q; mul_b = s11_q; end
      else if (cnt_q == CNT_W'(1))     begin mul_a = s22_q; mul_b = s22_q; end
      else if (cnt_q == CNT_W'(2))     begin mul_a = s21_q; mul_b = s11_q; end
      else if (cnt_q == CNT_W'(L+3))   begin mul_a = t_q;   mul_b = s22_q; end
      else if (cnt_q == CNT_W'(2*L+4)) begin mul_a = u_q;   mul_b = u_q;   end
      else if (cnt_q == CNT_W'(2*L+5)) begin mul_a = u_q;   mul_b = s22_q; end

      if      (cnt_q == CNT_W'(L))     m1_d = prod_out;
      else if (cnt_q == CNT_W'(L+1))   m2_d = prod_out;
      else if (cnt_q == CNT_W'(L+2))   t_d  = prod_out;
      else if (cnt_q == CNT_W'(2*L+3)) u_d  = prod_out;
      else if (cnt_q == CNT_W'(3*L+4)) m5_d = prod_out;
      else if (cnt_q == CNT_W'(3*L+5)) m6_d = prod_out;
    end

    pipe_d[0] = fx_mul(mul_a, mul_b);
    for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];

    case (state_q)
      IDLE: if (S_valid && !s_valid_d1_q) begin
        s11_d     = S[DATA_W-1:0];
        s21_d     = S[2*DATA_W-1:DATA_W];
        s22_d     = S[3*DATA_W-1:2*DATA_W];
        cnt_d     = '0;
        p_valid_d = 1'b0;
        busy_d    = 1'b1;
        state_d   = ISSUE_A;
      end
      ISSUE_A: if (cnt_q == CNT_W'(2))       state_d = WAIT_A;
      WAIT_A:  if (cnt_q == CNT_W'(L+2))     state_d = ISSUE_B;
      ISSUE_B:                               state_d = WAIT_B;
      WAIT_B:  if (cnt_q == CNT_W'(2*L+3))   state_d = ISSUE_C;
      ISSUE_C: if (cnt_q == CNT_W'(2*L+5))   state_d = WAIT_C;
      WAIT_C:  if (cnt_q == CNT_W'(3*L+5))   state_d = DONE;
      DONE: begin
        p_d       = {m2_q, fx_neg(m6_q), fx_add(m1_q, m5_q)};
        p_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s_valid_d1_q <= 1'b0;
      s11_q <= '0; s21_q <= '0; s22_q <= '0;
      m1_q  <= '0; m2_q  <= '0; t_q   <= '0;
      u_q   <= '0; m5_q  <= '0; m6_q  <= '0;
      for (int i = 0; i < L; i++) pipe_q[i] <= '0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_valid_d1_q <= s_valid_d1_d;
      s11_q <= s11_d; s21_q <= s21_d; s22_q <= s22_d;
      m1_q  <= m1_d;  m2_q  <= m2_d;  t_q   <= t_d;
      u_q   <= u_d;   m5_q  <= m5_d;  m6_q  <= m6_d;
      for (int i = 0; i < L; i++) pipe_q[i] <= pipe_d[i];
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign P       = p_q;
  assign P_valid = p_valid_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_inv_cov_2.sv
// Randomised bench for inv_cov_2 against an arithmetic model of P = L^-T L^-1.
// Covers latency, handshake, clock-enable stalls, saturation and mid-run reset.
module tb_inv_cov_2;
  logic        clk, rst, clk_en, S_valid, P_valid, busy;
  logic [95:0] S, P;
  int          n_cmp, n_bad;

  inv_cov_2 dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .S(S), .S_valid(S_valid),
    .P(P), .P_valid(P_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [31:0] clamp(input longint v);
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return 32'(v);
  endfunction

  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = sx(a) * sx(b);
    return clamp(p >>> 16);
  endfunction

  function automatic logic [95:0] ref_p(input logic [31:0] s11, input logic [31:0] s21, input logic [31:0] s22);
    logic [31:0] m1, m2, t, u, m5, m6;
    m1 = q_mul(s11, s11);
    m2 = q_mul(s22, s22);
    t  = q_mul(s21, s11);
    u  = q_mul(t, s22);
    m5 = q_mul(u, u);
    m6 = q_mul(u, s22);
    return {m2, clamp(-sx(m6)), clamp(sx(m1) + sx(m5))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    S_valid = 1'b0;
    tick();
  endtask

  // mode: 0 plain, 1 S_valid glitch mid-run, 2 clk_en gap, 3 early S_valid drop, 4 mid-run reset
  task automatic job(input logic [31:0] s11, input logic [31:0] s21, input logic [31:0] s22, input int mode);
    logic [95:0] exp, p_before;
    int          n, tot;
    bit          busy_ok, hold_ok, did_rst;
    exp      = ref_p(s11, s21, s22);
    p_before = P;
    S        = {s22, s21, s11};
    S_valid  = 1'b1;
    tick();
    check("capture_busy", {95'd0, busy}, 96'd1);
    check("capture_pvalid", {95'd0, P_valid}, 96'd0);
    n = 0; tot = 0; busy_ok = 1; hold_ok = 1; did_rst = 0;
    while (!P_valid && tot < 200) begin
      clk_en = !(mode == 2 && tot >= 10 && tot < 15);
      if (mode == 1) S_valid = (tot != 8);
      if (mode == 3 && tot == 20) S_valid = 1'b0;
      if (mode == 4 && tot == 15 && !did_rst) begin
        rst = 1'b0;
        tick();
        check("rst_P", P, 96'd0);
        check("rst_pvalid", {95'd0, P_valid}, 96'd0);
        check("rst_busy", {95'd0, busy}, 96'd0);
        rst = 1'b1; did_rst = 1; p_before = '0;
        tick();
        check("rst_recapture_busy", {95'd0, busy}, 96'd1);
        tot = 0; n = 0;
        continue;
      end
      tick();
      tot++;
      if (clk_en) n++;
      if (!P_valid) begin
        if (!busy) busy_ok = 0;
        if (P !== p_before) hold_ok = 0;
      end
    end
    clk_en = 1'b1;
    check("latency_edges", 96'(tot), 96'(28 + ((mode == 2) ? 5 : 0)));
    check("latency_enabled", 96'(n), 96'd28);
    check("result_P", P, exp);
    check("done_busy", {95'd0, busy}, 96'd0);
    check("busy_during_run", {95'd0, busy_ok}, 96'd1);
    check("P_held_during_run", {95'd0, hold_ok}, 96'd1);
  endtask

  localparam logic [31:0] N11 = 32'h0000_8000, N21 = 32'h0002_0000, N22 = 32'h0001_0000;

  initial begin
    bit          quiet;
    logic [31:0] a, b, c;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; clk_en = 1'b1; S_valid = 1'b0; S = '0;
    tick(); tick();
    check("reset_P", P, 96'd0);
    check("reset_pvalid", {95'd0, P_valid}, 96'd0);
    check("reset_busy", {95'd0, busy}, 96'd0);
    rst = 1'b1;
    tick();

    job(N11, N21, N22, 0);
    check("nominal_const", P, 96'h00010000_FFFF0000_00014000);
    quiet = 1;
    repeat (35) begin
      tick();
      if (busy || !P_valid) quiet = 0;
    end
    check("held_valid_single_result", {95'd0, quiet}, 96'd1);

    drop(); job(N11, 32'hFFFE_0000, N22, 1);
    check("sign_const", P, 96'h00010000_00010000_00014000);
    drop(); job(32'h0100_0000, 32'h0, N22, 0);
    check("sat_const", P, 96'h00010000_00000000_7FFFFFFF);
    drop(); job(N11, N21, N22, 2);
    check("clken_const", P, 96'h00010000_FFFF0000_00014000);
    drop(); job(N11, N21, N22, 3);
    job(N11, 32'hFFFE_0000, N22, 0);
    check("b2b_const", P, 96'h00010000_00010000_00014000);
    drop(); job(N11, N21, N22, 4);
    check("after_reset_const", P, 96'h00010000_FFFF0000_00014000);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom; b = $urandom; c = $urandom;
      end else begin
        a = 32'($urandom_range(0, 32'h0004_0000));
        b = 32'(int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
        c = 32'($urandom_range(0, 32'h0004_0000));
      end
      drop();
      job(a, b, c, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inv_cov_2.md
Name: inv_cov_2

Overview:
- Consumes the packed 2x2 "Inverse-Cholesky" matrix S produced by the covariance factoriser and reconstructs the inverse covariance P = A^-1 = L^-T L^-1.
- The reconstruction uses multiplies, saturating adds and negation only; no divide or square root.
- Sits directly downstream of the factoriser on the S / S_valid interface. P feeds the filter update stage.
- Uses one pipelined, time-multiplexed signed Q16.16 multiplier, sequenced by a small FSM.

Parameters:
- MULT_LAT, 7: multiplier pipeline depth. An operand pair presented in cycle k produces its product in cycle k+MULT_LAT.
- DATA_W, 32: element width, signed Q16.16. Fixed at 32; not intended to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low: asserted when rst==0 at a rising clk edge.
- clk_en  in  1  global enable. When low, all state, the multiplier pipeline and outputs hold.
- S  in  96  packed input {S22, S21, S11}, each Q16.16. S11 and S22 are inverse square roots of the pivots; S21 is L21.
- S_valid  in  1  level valid from the producer. It stays high until the producer starts its next job.
- P  out  96  packed output {P22, P21, P11}: lower triangle of the symmetric A^-1, Q16.16.
- P_valid  out  1  level; high while P holds a finished result.
- busy  out  1  high from the capture edge until the edge on which P_valid rises.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, P=0, P_valid=0, busy=0, internal operand/result registers=0, s_valid_d1=0.
  - Reset mid-operation aborts immediately; no partial P is written.
- Start detection: s_valid_d1 registers S_valid on every enabled edge.
  - Start = S_valid & ~s_valid_d1 while in IDLE.
  - S_valid already high out of reset counts as a rise.
  - Rises while busy are ignored, not queued; the producer must drop and re-raise S_valid.
- Capture edge (cycle 0): latch S11/S21/S22, P_valid<=0, busy<=1. P keeps its old value until it is overwritten.
- Multiply rule: full 64-bit signed product, result = bits[47:16].
  - Truncation is arithmetic, i.e. floor.
  - If bits[63:47] are not all equal, saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative).
- Schedule, with cycles counted from the capture edge and L=MULT_LAT:
  - c1 issue m1=S11*S11; c2 issue m2=S22*S22; c3 issue m3=S21*S11.
  - c3+L register t=m3; c4+L issue m4=t*S22.
  - c4+2L register u=m4; c5+2L issue m5=u*u; c6+2L issue m6=u*S22.
  - c1+L register m1; c2+L register m2; c5+3L register m5; c6+3L register m6.
  - c7+3L: P11<=sat(m1+m5), P21<=sat(-m6), P22<=m2; P_valid<=1; busy<=0.
  - sat(-0x80000000) = 0x7FFFFFFF. The add saturates on signed overflow.
- Latency: P_valid rises exactly 7+3*MULT_LAT enabled cycles after the capture edge (28 for the default).
- FSM states: IDLE -> ISSUE_A (c1..c3) -> WAIT_A -> ISSUE_B (m4) -> WAIT_B -> ISSUE_C (m5, m6) -> WAIT_C -> DONE (1 cycle, writes P) -> IDLE.
  - A cycle counter selects the issue and sample points. The counter is sized for 7+3*MULT_LAT.
- clk_en low: the FSM, counter, multiplier pipeline, s_valid_d1, P, P_valid and busy all freeze. The schedule resumes unchanged, and latency counts enabled cycles only.
- P_valid stays high in IDLE until the next capture edge. A new capture can occur on the edge directly after P_valid rises.

Test Plan:
- Nominal: S11=0x00008000, S21=0x00020000, S22=0x00010000 (A=[[4,4],[4,5]]) -> P11=0x00014000, P21=0xFFFF0000, P22=0x00010000; P_valid at cycle 28.
- Sign: same inputs with S21=0xFFFE0000 -> P21=0x00010000; P11 and P22 unchanged.
- Saturation: S11=0x01000000, S21=0, S22=0x00010000 -> P11=0x7FFFFFFF, P21=0, P22=0x00010000.
- Handshake: hold S_valid high through completion -> exactly one result. Pulse S_valid low then high mid-run -> ignored; busy/P_valid timing unchanged. Back-to-back rise right after P_valid -> second result 28 cycles later.
- clk_en: deassert for 5 cycles at c10 -> P_valid at cycle 33 with values identical to the nominal case.
- Reset: drive rst=0 at c15 -> next edge P=0, P_valid=0, busy=0. After release with S_valid held high, a new capture occurs and the nominal result follows.
